// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle data-memory responder with lane-aligned loads and stores
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  ByteSel,
  input  logic        LoadUnsigned,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Stall,
  output logic        Misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic [3:0]    count;
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic          unsigned_q;
  logic          store_q;
  logic [31:0]   wdata_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          request;
  logic          aligned;
  logic          accept;
  logic          finish;

  // Access attributes used at commit time: live inputs when committing
  // straight out of IDLE (LATENCY=1), captured copies otherwise.
  logic [AW+1:0] c_addr;
  logic [1:0]    c_size;
  logic          c_uns;
  logic          c_store;
  logic [31:0]   c_wdata;
  logic [AW-1:0] c_idx;
  logic [31:0]   rd_word;
  logic [3:0]    lane_en;
  logic [31:0]   lane_data;
  logic [31:0]   load_val;
  logic [31:0]   byte_shift;
  logic [31:0]   half_shift;

  // Upper address bits are deliberately ignored so addresses wrap.
  logic unused_addr;
  assign unused_addr = ^Address[31:AW+2];

  assign request = MemRead | MemWrite;
  assign accept  = !Reset && (state == IDLE) && request && aligned;
  assign finish  = !Reset && ((accept && (LATENCY == 1)) ||
                              ((state == BUSY) && (count == 4'd1)));
  assign Stall   = !Reset && (((state == IDLE) && request && aligned) ||
                              (state == BUSY));

  // Alignment rule per access size; size code 11 is never legal.
  always_comb begin
    aligned = 1'b0;
    case (ByteSel)
      2'b00:   aligned = (Address[1:0] == 2'b00);
      2'b01:   aligned = 1'b1;
      2'b10:   aligned = !Address[0];
      default: aligned = 1'b0;
    endcase
  end

  // Pick live or captured request fields for the commit edge.
  always_comb begin
    if (state == IDLE) begin
      c_addr  = Address[AW+1:0];
      c_size  = ByteSel;
      c_uns   = LoadUnsigned;
      c_store = MemWrite;
      c_wdata = WriteData;
    end else begin
      c_addr  = addr_q;
      c_size  = size_q;
      c_uns   = unsigned_q;
      c_store = store_q;
      c_wdata = wdata_q;
    end
  end

  assign c_idx   = c_addr[AW+1:2];
  assign rd_word = mem[c_idx];

  // Byte-lane enables and replicated store data, little-endian lanes.
  always_comb begin
    lane_en   = 4'b1111;
    lane_data = c_wdata;
    case (c_size)
      2'b01: begin
        lane_en   = 4'b0001 << c_addr[1:0];
        lane_data = {4{c_wdata[7:0]}};
      end
      2'b10: begin
        lane_en   = c_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{c_wdata[15:0]}};
      end
      default: begin
        lane_en   = 4'b1111;
        lane_data = c_wdata;
      end
    endcase
  end

  // Shift the addressed lane(s) down to bit 0 and extend.
  always_comb begin
    byte_shift = rd_word >> {c_addr[1:0], 3'b000};
    half_shift = rd_word >> {c_addr[1], 4'b0000};
    case (c_size)
      2'b01:   load_val = c_uns ? {24'b0, byte_shift[7:0]}
                                : {{24{byte_shift[7]}}, byte_shift[7:0]};
      2'b10:   load_val = c_uns ? {16'b0, half_shift[15:0]}
                                : {{16{half_shift[15]}}, half_shift[15:0]};
      default: load_val = rd_word;
    endcase
  end

  // Store commit on the edge entering RESP; RAM is never cleared.
  always_ff @(posedge Clock) begin
    if (finish && c_store) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) mem[c_idx][8*k +: 8] <= lane_data[8*k +: 8];
      end
    end
  end

  // Control FSM with registered Ready, Misaligned and ReadData.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      count      <= 4'd0;
      ReadData   <= 32'd0;
      Ready      <= 1'b0;
      Misaligned <= 1'b0;
      addr_q     <= '0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      store_q    <= 1'b0;
      wdata_q    <= 32'd0;
    end else begin
      Ready      <= finish;
      Misaligned <= (state == IDLE) && request && !aligned;
      if (finish && !c_store) ReadData <= load_val;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q     <= Address[AW+1:0];
            size_q     <= ByteSel;
            unsigned_q <= LoadUnsigned;
            store_q    <= MemWrite;
            wdata_q    <= WriteData;
            count      <= CNT_INIT;
            state      <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          count <= count - 4'd1;
          if (count == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  byte_sel;
  logic        load_uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] read_data;
  logic        ready;
  logic        stall;
  logic        misaligned;

  int n_checks = 0;
  int n_pass   = 0;

  logic        check_en  = 1'b0;
  logic        exp_stall = 1'b0;
  logic        exp_ready = 1'b0;
  logic        exp_mis   = 1'b0;
  logic [31:0] exp_rdata = 32'd0;

  logic [31:0] mdl_mem [DEPTH];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .Clock(clk), .Reset(rst), .MemRead(mem_read), .MemWrite(mem_write),
    .ByteSel(byte_sel), .LoadUnsigned(load_uns), .Address(addr),
    .WriteData(wdata), .ReadData(read_data), .Ready(ready), .Stall(stall),
    .Misaligned(misaligned)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Every cycle: outputs must match the transaction-level expectation.
  always @(negedge clk) begin
    if (check_en) begin
      chk("stall", {31'd0, stall}, {31'd0, exp_stall});
      chk("ready", {31'd0, ready}, {31'd0, exp_ready});
      chk("misaligned", {31'd0, misaligned}, {31'd0, exp_mis});
      chk("read_data", read_data, exp_rdata);
    end
  end

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] mdl_load(input logic [1:0] bs, input logic uns, input logic [31:0] a);
    logic [31:0] w, v;
    int lane;
    w = mdl_mem[widx(a)];
    lane = int'(a % 4);
    if (bs == 2'b01) begin
      v = (w >> (8 * lane)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (bs == 2'b10) begin
      v = (w >> (8 * (lane & 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else v = w;
    return v;
  endfunction

  task automatic mdl_store(input logic [1:0] bs, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w, mask;
    int sh;
    w = mdl_mem[widx(a)];
    if (bs == 2'b01) begin
      sh = 8 * int'(a % 4);
      mask = 32'hFF << sh;
      w = (w & ~mask) | ((d & 32'hFF) << sh);
    end else if (bs == 2'b10) begin
      sh = 8 * (int'(a % 4) & 2);
      mask = 32'hFFFF << sh;
      w = (w & ~mask) | ((d & 32'hFFFF) << sh);
    end else w = d;
    mdl_mem[widx(a)] = w;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    mem_read = 1'b0; mem_write = 1'b0; byte_sel = 2'b00;
    load_uns = 1'b0; addr = 32'd0; wdata = 32'd0;
  endtask

  // One request from acceptance to the first IDLE cycle afterwards.
  task automatic access(input logic rd, input logic wr, input logic [1:0] bs,
                        input logic uns, input logic [31:0] a, input logic [31:0] d);
    logic ok;
    ok = (bs == 2'b00 && a[1:0] == 2'b00) || bs == 2'b01 || (bs == 2'b10 && !a[0]);
    mem_read = rd; mem_write = wr; byte_sel = bs; load_uns = uns; addr = a; wdata = d;
    exp_stall = ok; exp_ready = 1'b0; exp_mis = 1'b0;
    next_cycle();
    if (!ok) begin
      go_idle();
      exp_mis = 1'b1; exp_stall = 1'b0;
      next_cycle();
      exp_mis = 1'b0;
      return;
    end
    for (int c = 1; c < LAT; c++) begin
      addr = $urandom; wdata = $urandom; byte_sel = 2'($urandom); load_uns = ~uns;
      exp_stall = 1'b1;
      next_cycle();
    end
    go_idle();
    if (wr) mdl_store(bs, a, d);
    else exp_rdata = mdl_load(bs, uns, a);
    exp_stall = 1'b0; exp_ready = 1'b1;
    next_cycle();
    exp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    go_idle();
    mem_read = 1'b1; addr = 32'h10;
    next_cycle();
    check_en = 1'b1;
    next_cycle();
    rst = 1'b0;
    go_idle();
    next_cycle();

    access(0, 1, 2'b00, 0, 32'h10, 32'hDEADBEEF);
    access(1, 0, 2'b00, 0, 32'h10, 32'h0);
    chk("lw_0x10", read_data, 32'hDEADBEEF);
    next_cycle();
    chk("lw_0x10_held", read_data, 32'hDEADBEEF);

    access(0, 1, 2'b00, 0, 32'h20, 32'h11223344);
    access(1, 0, 2'b01, 0, 32'h23, 32'h0);
    chk("lb_0x23", read_data, 32'h00000011);
    access(1, 0, 2'b01, 0, 32'h21, 32'h0);
    chk("lb_0x21", read_data, 32'h00000033);
    access(0, 1, 2'b01, 0, 32'h22, 32'h12345680);
    access(1, 0, 2'b01, 0, 32'h22, 32'h0);
    chk("lb_0x22", read_data, 32'hFFFFFF80);
    access(1, 0, 2'b01, 1, 32'h22, 32'h0);
    chk("lbu_0x22", read_data, 32'h00000080);
    access(1, 0, 2'b00, 0, 32'h20, 32'h0);
    chk("lw_0x20", read_data, 32'h11803344);

    access(0, 1, 2'b00, 0, 32'h40, 32'hA5A5A5A5);
    access(0, 1, 2'b10, 0, 32'h42, 32'h77778001);
    access(1, 0, 2'b10, 0, 32'h42, 32'h0);
    chk("lh_0x42", read_data, 32'hFFFF8001);
    access(1, 0, 2'b00, 0, 32'h40, 32'h0);
    chk("lw_0x40", read_data, 32'h8001A5A5);
    access(1, 0, 2'b10, 1, 32'h40, 32'h0);
    chk("lhu_0x40", read_data, 32'h0000A5A5);

    access(1, 0, 2'b00, 0, 32'h13, 32'h0);
    access(1, 0, 2'b10, 0, 32'h11, 32'h0);
    access(0, 1, 2'b11, 0, 32'h10, 32'h0);
    access(0, 1, 2'b00, 0, 32'h12, 32'h0);
    chk("rdata_after_mis", read_data, 32'h0000A5A5);
    access(1, 0, 2'b00, 0, 32'h10, 32'h0);
    chk("lw_0x10_intact", read_data, 32'hDEADBEEF);

    access(1, 1, 2'b00, 0, 32'h30, 32'h13579BDF);
    chk("rw_both_no_load", read_data, 32'hDEADBEEF);
    access(1, 0, 2'b00, 0, 32'h30, 32'h0);
    chk("lw_0x30", read_data, 32'h13579BDF);

    access(0, 1, 2'b00, 0, 32'h0, 32'hCAFEF00D);
    mem_write = 1'b1; addr = 32'h0; wdata = 32'h5;
    exp_stall = 1'b1;
    next_cycle();
    rst = 1'b1;
    exp_stall = 1'b0;
    next_cycle();
    rst = 1'b0;
    go_idle();
    exp_rdata = 32'd0;
    next_cycle();
    access(1, 0, 2'b00, 0, 32'h0, 32'h0);
    chk("lw_0x0_after_abort", read_data, 32'hCAFEF00D);

    access(0, 1, 2'b00, 0, 32'h1000, 32'h600DCAFE);
    access(1, 0, 2'b00, 0, 32'h0, 32'h0);
    chk("lw_wrap", read_data, 32'h600DCAFE);

    next_cycle();
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
